// File: rtl/test_sink_checker.sv
// test_sink_checker: checks an incoming I/Q AXI-Stream for equal incrementing 12-bit ramps, with optional periodic backpressure
module test_sink_checker #(
  parameter int CNT_W      = 32,
  parameter int THR_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [23:0]      in_data,
  output logic             in_ready,
  input  logic             throttle_en,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [23:0]      last_bad
);
  localparam int TW = (THR_PERIOD > 1) ? $clog2(THR_PERIOD) : 1;
  localparam logic [TW-1:0] THR_LAST = TW'(THR_PERIOD - 1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] thr_q, thr_d;
  logic rdy_q, rdy_d;
  logic [23:0] exp_q, exp_d, bad_q, bad_d;
  logic flag_q, flag_d;
  logic [CNT_W-1:0] err_q, err_d, smp_q, smp_d;
  logic beat, bad;
  logic [11:0] lane_i, lane_q;
  assign lane_i = in_data[11:0];
  assign lane_q = in_data[23:12];
  assign beat = in_valid & rdy_q;
  // free-running throttle counter; ready is registered so it is low while the counter sits at its last value
  always_comb begin
    thr_d = (thr_q == THR_LAST) ? '0 : thr_q + TW'(1);
    rdy_d = !(throttle_en && thr_d == THR_LAST);
  end
  // ramp checker: lock on first beat, then compare each beat with the previous one plus one and resync
  always_comb begin
    bad = (lane_i != lane_q) || (state_q == LOCKED && in_data != exp_q);
    state_d = state_q;
    exp_d = exp_q;
    bad_d = bad_q;
    flag_d = flag_q;
    err_d = err_q;
    smp_d = smp_q;
    if (clear) begin
      state_d = UNLOCKED;
      exp_d = '0;
      bad_d = '0;
      flag_d = 1'b0;
      err_d = '0;
      smp_d = '0;
    end else if (beat) begin
      state_d = LOCKED;
      exp_d = {lane_q + 12'd1, lane_i + 12'd1};
      smp_d = (&smp_q) ? smp_q : smp_q + CNT_W'(1);
      flag_d = flag_q | bad;
      err_d = (bad && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
      bad_d = bad ? in_data : bad_q;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q <= '0;
      rdy_q <= 1'b0;
      state_q <= UNLOCKED;
      exp_q <= '0;
      bad_q <= '0;
      flag_q <= 1'b0;
      err_q <= '0;
      smp_q <= '0;
    end else begin
      thr_q <= thr_d;
      rdy_q <= rdy_d;
      state_q <= state_d;
      exp_q <= exp_d;
      bad_q <= bad_d;
      flag_q <= flag_d;
      err_q <= err_d;
      smp_q <= smp_d;
    end
  end
  assign in_ready = rdy_q;
  assign locked = (state_q == LOCKED);
  assign err_flag = flag_q;
  assign err_count = err_q;
  assign sample_count = smp_q;
  assign last_bad = bad_q;
endmodule

// File: tb/tb_test_sink_checker.sv
// tb_test_sink_checker: table vectors, directed sequences and random stimulus against a behavioural model
module tb_test_sink_checker;
  localparam int P = 8;
  logic clk = 0;
  logic rst_i = 1, clear_i = 0, vld_i = 0, te_i = 0;
  logic [23:0] data_i = 0;
  logic in_ready, locked, err_flag, in_ready2, locked2, err_flag2;
  logic [31:0] err_count, sample_count;
  logic [3:0] err_count2, sample_count2;
  logic [23:0] last_bad, last_bad2;
  int errors = 0, checks = 0;
  bit m_locked, m_ready;
  logic [23:0] m_prev, m_bad;
  longint m_samp, m_err, m_n;
  always #5 clk = ~clk;

  test_sink_checker #(.CNT_W(32), .THR_PERIOD(P)) dut (
    .clk(clk), .rst(rst_i), .in_valid(vld_i), .in_data(data_i), .in_ready(in_ready),
    .throttle_en(te_i), .clear(clear_i), .locked(locked), .err_flag(err_flag),
    .err_count(err_count), .sample_count(sample_count), .last_bad(last_bad));

  test_sink_checker #(.CNT_W(4), .THR_PERIOD(P)) dut2 (
    .clk(clk), .rst(rst_i), .in_valid(vld_i), .in_data(data_i), .in_ready(in_ready2),
    .throttle_en(te_i), .clear(clear_i), .locked(locked2), .err_flag(err_flag2),
    .err_count(err_count2), .sample_count(sample_count2), .last_bad(last_bad2));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model of the checker: lock on first beat, then each beat must be previous+1 mod 4096 on both lanes, I==Q always
  task automatic model_edge();
    int pi, pq, ci, cq;
    bit acc, bad;
    if (rst_i) begin
      m_locked = 0; m_prev = 0; m_samp = 0; m_err = 0; m_bad = 0; m_n = 0; m_ready = 0;
    end else begin
      acc = vld_i && m_ready;
      m_n++;
      if (clear_i) begin
        m_locked = 0; m_prev = 0; m_samp = 0; m_err = 0; m_bad = 0;
      end else if (acc) begin
        pi = m_prev[11:0]; pq = m_prev[23:12]; ci = data_i[11:0]; cq = data_i[23:12];
        bad = (ci != cq) || (m_locked && (ci != (pi + 1) % 4096 || cq != (pq + 1) % 4096));
        m_locked = 1;
        m_prev = data_i;
        m_samp++;
        if (bad) begin
          m_err++;
          m_bad = data_i;
        end
      end
      m_ready = !(te_i && (m_n % P == P - 1));
    end
  endtask

  task automatic cyc();
    chk("in_ready", in_ready, m_ready);
    @(posedge clk);
    model_edge();
    #1;
    chk("locked", locked, m_locked);
    chk("err_flag", err_flag, m_err != 0);
    chk("err_count", err_count, m_err);
    chk("sample_count", sample_count, m_samp);
    chk("last_bad", last_bad, m_bad);
    chk("sat_err_count", err_count2, (m_err > 15) ? 15 : m_err);
    chk("sat_sample_count", sample_count2, (m_samp > 15) ? 15 : m_samp);
  endtask

  task automatic send(input logic [23:0] d);
    bit acc;
    bit done;
    done = 0;
    vld_i = 1;
    data_i = d;
    for (int k = 0; k < 20 && !done; k++) begin
      acc = m_ready;
      cyc();
      done = acc;
    end
    chk("send_accepted", done, 1'b1);
    vld_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; vld_i = 0; clear_i = 0;
    cyc();
    rst_i = 0;
  endtask

  typedef struct {
    bit rst, clr, vld;
    logic [23:0] d;
    bit lk;
    int smp, err;
    logic [23:0] bad;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [11:0] v, ri, rq;
    int beats, lows;
    bit acc;
    tbl[0]  = '{1, 0, 1, 24'h00e00e, 0, 0, 0, 24'h0};
    tbl[1]  = '{0, 0, 1, 24'h00e00e, 0, 0, 0, 24'h0};
    tbl[2]  = '{0, 0, 1, 24'h00e00e, 1, 1, 0, 24'h0};
    tbl[3]  = '{0, 0, 1, 24'h00f00f, 1, 2, 0, 24'h0};
    tbl[4]  = '{0, 0, 1, 24'h010010, 1, 3, 0, 24'h0};
    tbl[5]  = '{0, 0, 1, 24'h055055, 1, 4, 1, 24'h055055};
    tbl[6]  = '{0, 0, 1, 24'h012012, 1, 5, 2, 24'h012012};
    tbl[7]  = '{0, 0, 1, 24'h013013, 1, 6, 2, 24'h012012};
    tbl[8]  = '{0, 0, 0, 24'habcabc, 1, 6, 2, 24'h012012};
    tbl[9]  = '{0, 0, 1, 24'h014014, 1, 7, 2, 24'h012012};
    tbl[10] = '{0, 1, 1, 24'h999999, 0, 0, 0, 24'h0};
    tbl[11] = '{0, 0, 1, 24'h123123, 1, 1, 0, 24'h0};
    tbl[12] = '{0, 0, 1, 24'h124124, 1, 2, 0, 24'h0};
    m_locked = 0; m_ready = 0; m_prev = 0; m_bad = 0; m_samp = 0; m_err = 0; m_n = 0;
    @(posedge clk);
    model_edge();
    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_counts", {err_count, sample_count}, 64'h0);
    chk("reset_flags", {locked, err_flag, last_bad}, 26'h0);
    // glitch, idle and clear vectors
    foreach (tbl[i]) begin
      rst_i = tbl[i].rst; clear_i = tbl[i].clr; vld_i = tbl[i].vld; data_i = tbl[i].d;
      cyc();
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_samples", i), sample_count, tbl[i].smp);
      chk($sformatf("tbl%0d_errors", i), err_count, tbl[i].err);
      chk($sformatf("tbl%0d_flag", i), err_flag, tbl[i].err != 0);
      chk($sformatf("tbl%0d_last_bad", i), last_bad, tbl[i].bad);
    end
    clear_i = 0;
    // long clean ramp through the 0xFFF wrap
    do_reset();
    v = 12'($urandom);
    beats = 0;
    for (int k = 0; k < 20000 && beats < 5000; k++) begin
      vld_i = ($urandom_range(0, 9) != 0);
      data_i = {v, v};
      acc = vld_i && m_ready;
      cyc();
      if (acc) begin
        v = v + 12'd1;
        beats++;
      end
    end
    chk("ramp_beats", beats, 5000);
    chk("ramp_samples", sample_count, 5000);
    chk("ramp_errors", err_count, 0);
    chk("ramp_locked", locked, 1'b1);
    // lane mismatch inside a ramp
    do_reset();
    send(24'h01e01e);
    send(24'h01f01f);
    send(24'h021020);
    chk("lane_last_bad", last_bad, 24'h021020);
    chk("lane_err_ge1", err_count >= 1, 1'b1);
    send(24'h021021);
    send(24'h022022);
    // throttle pattern with a source that honours ready
    te_i = 1;
    do_reset();
    for (int k = 0; k < 3; k++) cyc();
    v = 12'h7f0;
    lows = 0;
    vld_i = 1;
    for (int k = 0; k < 80; k++) begin
      data_i = {v, v};
      acc = m_ready;
      lows += (in_ready == 1'b0);
      cyc();
      if (acc) v = v + 12'd1;
    end
    vld_i = 0;
    chk("thr_lows", lows, 10);
    chk("thr_samples", sample_count, 70);
    chk("thr_errors", err_count, 0);
    te_i = 0;
    // saturation of the 4-bit counters
    do_reset();
    beats = 0;
    for (int k = 0; k < 60 && beats < 20; k++) begin
      ri = 12'($urandom);
      rq = ri ^ 12'($urandom_range(1, 4095));
      vld_i = 1;
      data_i = {rq, ri};
      acc = m_ready;
      cyc();
      beats += acc;
    end
    vld_i = 0;
    chk("sat_beats", beats, 20);
    chk("sat_err_held", err_count2, 4'd15);
    chk("sat_smp_held", sample_count2, 4'd15);
    chk("wide_err", err_count, 20);
    // random mix of ramps, glitches, clears, resets and throttling
    v = 12'($urandom);
    for (int k = 0; k < 1500; k++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      clear_i = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) te_i = ~te_i;
      vld_i = ($urandom_range(0, 3) != 0);
      data_i = ($urandom_range(0, 29) == 0) ? 24'($urandom) : {v, v};
      acc = vld_i && m_ready && !rst_i && !clear_i;
      cyc();
      if (acc) v = data_i[11:0] + 12'd1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
